// File: rtl/regfile_read_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_read_arbiter
//
// Shares the single mux-tree read port of a 32-entry register file among NREQ
// requesters (e.g. operand read, debug read, store-data read). A round-robin
// arbiter grants at most one requester per cycle. The winner's register number
// is registered onto the read-port select lines (stage 1). The combinational
// read data is registered one cycle later (stage 2) and handed back to the
// winner with a one-hot valid.
//
// Ports
//   clk        in   1          system clock, rising edge
//   reset_n    in   1          asynchronous active-low reset
//   req        in   NREQ       per-requester request level
//   raddr      in   NREQ*AW    requester i address at [i*AW +: AW]
//   hold       in   1          1 = issue no new grants (in-flight reads finish)
//   gnt        out  NREQ       one-hot grant (combinational)
//   port_sel   out  AW         registered select to the register file mux
//   port_data  in   DW         combinational read data for port_sel
//   rdata      out  DW         registered read result
//   rvalid     out  NREQ       one-hot: rdata belongs to requester i this cycle
//   busy       out  1          a read is in stage 1 or stage 2
// -----------------------------------------------------------------------------
module regfile_read_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 64,
    parameter int AW   = 5
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*AW-1:0]   raddr,
    input  logic                 hold,
    output logic [NREQ-1:0]      gnt,
    output logic [AW-1:0]        port_sel,
    input  logic [DW-1:0]        port_data,
    output logic [DW-1:0]        rdata,
    output logic [NREQ-1:0]      rvalid,
    output logic                 busy
);

    // Width of a requester index / round-robin pointer.
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PW-1:0]   r_rr_ptr;
    logic [AW-1:0]   r_port_sel;
    logic            r_s1_valid;
    logic [PW-1:0]   r_s1_owner;
    logic [DW-1:0]   r_rdata;
    logic [NREQ-1:0] r_rvalid;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    // w_scan_idx[k] is the requester examined k-th, starting from r_rr_ptr
    // and wrapping modulo NREQ; w_scan_req is req rotated into that order.
    logic [PW-1:0]   w_scan_idx [NREQ];
    logic [NREQ-1:0] w_scan_req;
    logic            w_found;
    logic [PW-1:0]   w_win_idx;
    logic            w_gnt_valid;
    logic [PW-1:0]   w_next_ptr;
    logic [NREQ-1:0] w_gnt;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_scan
            assign w_scan_idx[gi] = PW'((int'(r_rr_ptr) + gi) % NREQ);
            assign w_scan_req[gi] = req[w_scan_idx[gi]];
        end
    endgenerate

    // First set request in rotated order wins.
    always_comb begin
        w_found   = 1'b0;
        w_win_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && w_scan_req[k]) begin
                w_found   = 1'b1;
                w_win_idx = w_scan_idx[k];
            end
        end
    end

    // Grants are suppressed while in reset and while hold is asserted.
    assign w_gnt_valid = reset_n & ~hold & w_found;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_gnt
            assign w_gnt[gi] = w_gnt_valid && (w_win_idx == PW'(gi));
        end
    endgenerate

    // Pointer moves to the requester just after the winner.
    assign w_next_ptr = (w_win_idx == PW'(NREQ - 1)) ? '0 : (w_win_idx + 1'b1);

    // ------------------------------------------------------------------
    // Winner address select
    // ------------------------------------------------------------------
    // AND-OR mux keyed on the one-hot grant: addresses of non-granted
    // requesters are masked to zero, so X on them cannot reach port_sel.
    logic [AW-1:0] w_masked_addr [NREQ];
    logic [AW-1:0] w_sel_addr;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_addr
            assign w_masked_addr[gi] = {AW{w_gnt[gi]}} & raddr[gi*AW +: AW];
        end
    endgenerate

    always_comb begin
        w_sel_addr = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_sel_addr = w_sel_addr | w_masked_addr[k];
        end
    end

    // ------------------------------------------------------------------
    // Stage-2 helpers
    // ------------------------------------------------------------------
    logic [NREQ-1:0] w_owner_onehot;
    logic            w_zero_reg;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_owner
            assign w_owner_onehot[gi] = (r_s1_owner == PW'(gi));
        end
    endgenerate

    // The highest register number (31 for AW=5) is hard-wired to read zero.
    assign w_zero_reg = &r_port_sel;

    // ------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rr_ptr   <= '0;
            r_port_sel <= '0;
            r_s1_valid <= 1'b0;
            r_s1_owner <= '0;
            r_rdata    <= '0;
            r_rvalid   <= '0;
        end else begin
            // Stage 1: accept the grant and drive the read-port select.
            if (w_gnt_valid) begin
                r_port_sel <= w_sel_addr;
                r_s1_valid <= 1'b1;
                r_s1_owner <= w_win_idx;
                r_rr_ptr   <= w_next_ptr;
            end else begin
                r_s1_valid <= 1'b0;
            end

            // Stage 2: capture read data for the stage-1 owner. rdata holds
            // when there is nothing to return.
            if (r_s1_valid) begin
                r_rdata  <= w_zero_reg ? '0 : port_data;
                r_rvalid <= w_owner_onehot;
            end else begin
                r_rvalid <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign gnt      = w_gnt;
    assign port_sel = r_port_sel;
    assign rdata    = r_rdata;
    assign rvalid   = r_rvalid;
    assign busy     = r_s1_valid | (|r_rvalid);

endmodule
